seg_display_ctrl: RTL and testbench
===================================

Name: seg_display_ctrl

Overview:
- Memory-mapped, parametrised multi-digit 7-segment display controller; next generation of the fixed 8-digit seg driver.
- Sits on the MMIO bus beside the LED and switch drivers; selected by the decoder's segment chip-select.
- Adds:
  - hex or decimal display, with sequential binary-to-BCD conversion;
  - leading-zero blanking;
  - per-digit enable mask;
  - blink;
  - register read-back.

Parameters:
- DIGITS, 8, number of digits scanned; 1..8.
- SPLIT, 4, digits with index < SPLIT use seg_lo; the rest use seg_hi.
- CLK_HZ, 23000000, clock frequency in Hz.
- SCAN_HZ, 1000, digit-advance rate in Hz.
- BLINK_TICKS, 250, scan ticks per blink half-period.
- SEG_ACT, 1, level meaning a segment is lit.
- AN_ACT, 1, level meaning an anode is enabled.

Ports:
- clock  in  1  system clock
- rst  in  1  synchronous, active-high reset
- cs  in  1  chip-select from the MMIO decoder
- wen  in  1  write strobe, qualified by cs
- ren  in  1  read strobe, qualified by cs
- addr  in  2  register select
- wdata  in  32  write data
- rdata  out  32  registered read data
- busy  out  1  decimal conversion in progress
- seg_lo  out  8  segments {dp,g..a} for digits < SPLIT
- seg_hi  out  8  segments {dp,g..a} for digits >= SPLIT
- an  out  DIGITS  one-hot anode enables

Behaviour:
- Reset: rst is synchronous and active-high on clock. It clears:
  - VALUE to 0 and MODE to 0;
  - MASK to all ones;
  - the digit shadow to 0;
  - scan index, prescaler, blink counter and blink phase to 0;
  - busy to 0 and rdata to 0.
  - Anodes and segments are driven inactive: an = ~AN_ACT, seg_lo = seg_hi = ~SEG_ACT.
- Registers:
  - addr 0: VALUE[31:0].
  - addr 1: MODE.
    - bit0 dec: 0 = hex, 1 = decimal.
    - bit1 lzb: leading-zero blanking.
    - bit2 blink enable.
  - addr 2: MASK[DIGITS-1:0].
  - addr 3: STATUS, read-only; bit0 = busy. Writes to addr 3 are ignored.
- Write: cs & wen updates the register on the same edge.
- Read: cs & ren loads rdata on the next edge. Unused bits read 0. rdata holds its value otherwise.
- Shadow: digit shadow D[4*DIGITS-1:0] is what the display shows.
  - Hex mode: D = VALUE[4*DIGITS-1:0], loaded one cycle after a write to VALUE or MODE.
- Decimal conversion: starts on any write to VALUE or MODE while dec = 1. A write during conversion restarts it.
  - Double-dabble FSM with states IDLE -> SHIFT -> DONE -> IDLE.
  - SHIFT runs exactly 32 cycles. Each cycle: add 3 to every BCD nibble >= 5, then shift in the next VALUE bit, MSB first.
  - DONE copies the BCD result into D and drops busy.
  - busy is high from the cycle after the start event until DONE, i.e. 33 cycles.
  - D keeps its old value during conversion.
  - BCD register is 4*DIGITS wide, so the displayed value is VALUE mod 10^DIGITS.
- Scan:
  - Prescaler counts 0..CLK_HZ/SCAN_HZ-1. At wrap it pulses tick and advances the index by 1, wrapping DIGITS-1 -> 0.
  - Outputs are registered, one cycle after the index changes.
  - Exactly one anode may be active. The active digit's pattern goes to the matching seg group; the other group is ~SEG_ACT.
- Blanking: the digit is dark (anode inactive) when any of these holds:
  - MASK[i] = 0;
  - lzb = 1 and digit i is above the highest nonzero nibble; digit 0 is never blank by lzb;
  - blink = 1 and blink phase = 0.
- Blink: the blink counter advances on tick. Every BLINK_TICKS ticks the phase toggles. Clearing blink forces phase to 1.
- Decoder: nibbles 0-F map to the standard hex glyphs; dp is always off.

Decomposition:
- Shared package seg_pkg holds:
  - the glyph ROM constant (16 x 7 bits);
  - register address constants;
  - MODE bit indices.
- One sub-module, seg_bin2bcd: the sequential double-dabble converter with start/busy/done handshake, parametrised on DIGITS.

Test Plan:
- Reset: rst = 1 for 2 cycles -> an = 8'h00, seg_lo = seg_hi = 8'h00, busy = 0; MASK reads 8'hFF one cycle after a read.
- Hex scan: write VALUE = 32'h12AB34CD, MODE = 0 -> over 8 ticks the digits show D,C,4,3,B,A,2,1 in order. seg_lo is active for indices 0-3, seg_hi for 4-7, and exactly one an bit is high.
- Decimal: write MODE = 1 then VALUE = 32'd12345678 -> busy is high 33 cycles, then D = 32'h12345678. VALUE = 32'd4294967295 -> D = 32'h94967295.
- Restart mid-conversion: write VALUE = 99 at busy cycle 10 -> busy stays high 33 cycles from the rewrite, and D = 32'h00000099.
- Blanking: MODE = 3, VALUE = 42 -> only digits 0-1 lit. Then MASK = 8'hFE -> digit 0 dark as well.
- Blink: set blink with BLINK_TICKS = 2 -> all anodes off for 2 ticks, on for 2 ticks, alternating. Clearing blink lights the display on the next tick.

Source files
------------

// File: rtl/seg_pkg.sv
// Shared constants for the multi-digit 7-segment controller: glyph ROM,
// register map, MODE bit positions and the converter state type.
package seg_pkg;

    localparam logic [1:0] ADDR_VALUE  = 2'd0;
    localparam logic [1:0] ADDR_MODE   = 2'd1;
    localparam logic [1:0] ADDR_MASK   = 2'd2;
    localparam logic [1:0] ADDR_STATUS = 2'd3;

    localparam int MODE_DEC   = 0;
    localparam int MODE_LZB   = 1;
    localparam int MODE_BLINK = 2;
    localparam int MODE_W     = 3;

    // Segment order {g,f,e,d,c,b,a}; listed from glyph F down to glyph 0.
    localparam logic [15:0][6:0] GLYPH_ROM = {
        7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77, 7'h6F, 7'h7F,
        7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
    };

    typedef enum logic [1:0] {
        BCD_IDLE  = 2'd0,
        BCD_SHIFT = 2'd1,
        BCD_DONE  = 2'd2
    } bcd_state_t;

    function automatic logic [6:0] seg_glyph(input logic [3:0] nib);
        return GLYPH_ROM[nib];
    endfunction

endpackage

// File: rtl/seg_display_ctrl_if.sv
// MMIO register port of the segment display controller.
interface seg_display_ctrl_if;
    logic        cs;
    logic        wen;
    logic        ren;
    logic [1:0]  addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        busy;

    modport master (output cs, wen, ren, addr, wdata, input rdata, busy);
    modport slave  (input cs, wen, ren, addr, wdata, output rdata, busy);
endinterface

// File: rtl/seg_bin2bcd.sv
// Sequential double-dabble converter: 32 shift cycles then one DONE cycle.
// A start while busy restarts; the BCD result is value mod 10^DIGITS.
module seg_bin2bcd
    import seg_pkg::*;
#(
    parameter int DIGITS = 8
) (
    input  logic                clock,
    input  logic                rst,
    input  logic                i_start,
    input  logic                i_abort,
    input  logic [31:0]         i_value,
    output logic                o_busy,
    output logic                o_done,
    output logic [4*DIGITS-1:0] o_bcd
);
    localparam int BCD_W = 4 * DIGITS;

    bcd_state_t       r_state;
    bcd_state_t       w_next;
    logic [BCD_W-1:0] r_bcd;
    logic [BCD_W-1:0] w_adj;
    logic [31:0]      r_shift;
    logic [4:0]       r_cnt;

    always_ff @(posedge clock) begin
        if (rst) r_state <= BCD_IDLE;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        if (i_abort) begin
            w_next = BCD_IDLE;
        end else if (i_start) begin
            w_next = BCD_SHIFT;
        end else begin
            case (r_state)
                BCD_SHIFT: if (r_cnt == 5'd0) w_next = BCD_DONE;
                BCD_DONE:  w_next = BCD_IDLE;
                default:   w_next = BCD_IDLE;
            endcase
        end
    end

    always_comb begin
        o_busy = 1'b0;
        o_done = 1'b0;
        case (r_state)
            BCD_SHIFT: o_busy = 1'b1;
            BCD_DONE: begin
                o_busy = 1'b1;
                o_done = !i_start && !i_abort;
            end
            default: begin end
        endcase
    end

    always_comb begin
        w_adj = r_bcd;
        for (int i = 0; i < DIGITS; i++) begin
            if (r_bcd[4*i +: 4] >= 4'd5) w_adj[4*i +: 4] = r_bcd[4*i +: 4] + 4'd3;
        end
    end

    // Counter runs 31..0 so the shift on the terminal count is the 32nd.
    always_ff @(posedge clock) begin
        if (rst) begin
            r_bcd   <= '0;
            r_shift <= '0;
            r_cnt   <= '0;
        end else if (i_start) begin
            r_bcd   <= '0;
            r_shift <= i_value;
            r_cnt   <= 5'd31;
        end else if (r_state == BCD_SHIFT) begin
            r_bcd   <= {w_adj[BCD_W-2:0], r_shift[31]};
            r_shift <= {r_shift[30:0], 1'b0};
            r_cnt   <= r_cnt - 5'd1;
        end
    end

    assign o_bcd = r_bcd;

endmodule

// File: rtl/seg_display_ctrl.sv
// Memory-mapped multi-digit 7-segment controller: hex/decimal shadow,
// leading-zero blanking, digit mask, blink and registered read-back.
module seg_display_ctrl
    import seg_pkg::*;
#(
    parameter int DIGITS      = 8,
    parameter int SPLIT       = 4,
    parameter int CLK_HZ      = 23000000,
    parameter int SCAN_HZ     = 1000,
    parameter int BLINK_TICKS = 250,
    parameter bit SEG_ACT     = 1'b1,
    parameter bit AN_ACT      = 1'b1
) (
    input  logic              clock,
    input  logic              rst,
    seg_display_ctrl_if.slave bus,
    output logic [7:0]        seg_lo,
    output logic [7:0]        seg_hi,
    output logic [DIGITS-1:0] an
);
    localparam int BCD_W = 4 * DIGITS;
    localparam int DIV   = CLK_HZ / SCAN_HZ;
    localparam int PRE_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int BLK_W = (BLINK_TICKS > 1) ? $clog2(BLINK_TICKS) : 1;

    logic [31:0]       r_value;
    logic [MODE_W-1:0] r_mode;
    logic [DIGITS-1:0] r_mask;
    logic [31:0]       r_rdata;
    logic [BCD_W-1:0]  r_shadow;
    logic              r_hex_load;
    logic [PRE_W-1:0]  r_presc;
    logic [IDX_W-1:0]  r_idx;
    logic [BLK_W-1:0]  r_blink_cnt;
    logic              r_blink_phase;
    logic [7:0]        r_seg_lo;
    logic [7:0]        r_seg_hi;
    logic [DIGITS-1:0] r_an;

    logic              w_wr;
    logic              w_rd;
    logic              w_upd;
    logic              w_next_dec;
    logic              w_start;
    logic              w_hex_upd;
    logic              w_busy;
    logic              w_done;
    logic              w_tick;
    logic              w_lit;
    logic [31:0]       w_next_value;
    logic [BCD_W-1:0]  w_bcd;
    logic [IDX_W-1:0]  w_hi_idx;
    logic [3:0]        w_nib;
    logic [7:0]        w_pat;
    logic [DIGITS-1:0] w_oh;

    assign w_wr  = bus.cs & bus.wen;
    assign w_rd  = bus.cs & bus.ren;
    assign w_upd = w_wr && (bus.addr == ADDR_VALUE || bus.addr == ADDR_MODE);

    // Post-write VALUE/dec so the converter starts on the write edge itself.
    assign w_next_value = (bus.addr == ADDR_VALUE) ? bus.wdata : r_value;
    assign w_next_dec   = (bus.addr == ADDR_MODE) ? bus.wdata[MODE_DEC] : r_mode[MODE_DEC];
    assign w_start      = w_upd && w_next_dec;
    assign w_hex_upd    = w_upd && !w_next_dec;

    always_ff @(posedge clock) begin
        if (rst) begin
            r_value <= '0;
            r_mode  <= '0;
            r_mask  <= '1;
        end else if (w_wr) begin
            case (bus.addr)
                ADDR_VALUE: r_value <= bus.wdata;
                ADDR_MODE:  r_mode  <= bus.wdata[MODE_W-1:0];
                ADDR_MASK:  r_mask  <= bus.wdata[DIGITS-1:0];
                default:    begin end
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (rst) begin
            r_rdata <= '0;
        end else if (w_rd) begin
            case (bus.addr)
                ADDR_VALUE: r_rdata <= r_value;
                ADDR_MODE:  r_rdata <= 32'(r_mode);
                ADDR_MASK:  r_rdata <= 32'(r_mask);
                default:    r_rdata <= {31'd0, w_busy};
            endcase
        end
    end

    assign bus.rdata = r_rdata;
    assign bus.busy  = w_busy;

    seg_bin2bcd #(.DIGITS(DIGITS)) u_bin2bcd (
        .clock   (clock),
        .rst     (rst),
        .i_start (w_start),
        .i_abort (w_hex_upd),
        .i_value (w_next_value),
        .o_busy  (w_busy),
        .o_done  (w_done),
        .o_bcd   (w_bcd)
    );

    always_ff @(posedge clock) begin
        if (rst) begin
            r_shadow   <= '0;
            r_hex_load <= 1'b0;
        end else begin
            r_hex_load <= w_hex_upd;
            if (w_done)          r_shadow <= w_bcd;
            else if (r_hex_load) r_shadow <= r_value[BCD_W-1:0];
        end
    end

    assign w_tick = (r_presc == PRE_W'(DIV - 1));

    always_ff @(posedge clock) begin
        if (rst) begin
            r_presc <= '0;
            r_idx   <= '0;
        end else if (w_tick) begin
            r_presc <= '0;
            r_idx   <= (r_idx == IDX_W'(DIGITS - 1)) ? '0 : r_idx + IDX_W'(1);
        end else begin
            r_presc <= r_presc + PRE_W'(1);
        end
    end

    always_ff @(posedge clock) begin
        if (rst) begin
            r_blink_cnt   <= '0;
            r_blink_phase <= 1'b0;
        end else if (!r_mode[MODE_BLINK]) begin
            r_blink_cnt   <= '0;
            r_blink_phase <= 1'b1;
        end else if (w_tick) begin
            if (r_blink_cnt == BLK_W'(BLINK_TICKS - 1)) begin
                r_blink_cnt   <= '0;
                r_blink_phase <= ~r_blink_phase;
            end else begin
                r_blink_cnt <= r_blink_cnt + BLK_W'(1);
            end
        end
    end

    // Highest nonzero nibble; stays 0 for an all-zero shadow so digit 0 remains lit.
    always_comb begin
        w_hi_idx = '0;
        for (int i = 0; i < DIGITS; i++) begin
            if (r_shadow[4*i +: 4] != 4'd0) w_hi_idx = IDX_W'(i);
        end
    end

    always_comb begin
        w_nib = r_shadow[{r_idx, 2'b00} +: 4];
        w_lit = r_mask[r_idx]
              && !(r_mode[MODE_LZB] && (r_idx > w_hi_idx))
              && !(r_mode[MODE_BLINK] && !r_blink_phase);
        w_pat = {1'b0, seg_glyph(w_nib)};
        w_oh  = w_lit ? (DIGITS'(1) << r_idx) : '0;
    end

    always_ff @(posedge clock) begin
        if (rst) begin
            r_an     <= {DIGITS{~AN_ACT}};
            r_seg_lo <= {8{~SEG_ACT}};
            r_seg_hi <= {8{~SEG_ACT}};
        end else begin
            r_an     <= w_oh ^ {DIGITS{~AN_ACT}};
            r_seg_lo <= (w_lit && int'(r_idx) < SPLIT)  ? (w_pat ^ {8{~SEG_ACT}}) : {8{~SEG_ACT}};
            r_seg_hi <= (w_lit && int'(r_idx) >= SPLIT) ? (w_pat ^ {8{~SEG_ACT}}) : {8{~SEG_ACT}};
        end
    end

    assign an     = r_an;
    assign seg_lo = r_seg_lo;
    assign seg_hi = r_seg_hi;

endmodule

// File: tb/tb_seg_display_ctrl.sv
// Self-checking bench for seg_display_ctrl: register table, decimal
// conversion timing, restart, blanking and blink.
module tb_seg_display_ctrl;
    localparam int DIGITS  = 8;
    localparam int CLK_HZ  = 8;
    localparam int SCAN_HZ = 1;
    localparam int DIV     = CLK_HZ / SCAN_HZ;
    localparam int BT      = 2;

    logic       clock = 1'b0;
    logic       rst   = 1'b1;
    logic [7:0] seg_lo;
    logic [7:0] seg_hi;
    logic [7:0] an;

    seg_display_ctrl_if bus();

    seg_display_ctrl #(
        .DIGITS(DIGITS), .SPLIT(4), .CLK_HZ(CLK_HZ), .SCAN_HZ(SCAN_HZ),
        .BLINK_TICKS(BT), .SEG_ACT(1'b1), .AN_ACT(1'b1)
    ) dut (
        .clock  (clock),
        .rst    (rst),
        .bus    (bus),
        .seg_lo (seg_lo),
        .seg_hi (seg_hi),
        .an     (an)
    );

    always #5 clock = ~clock;

    logic [6:0] tb_glyph [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                  7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

    // Scan position model: m_idx_out is the digit the registered outputs show.
    int m_presc, m_idx, m_idx_out;
    always @(posedge clock) begin
        if (rst) begin
            m_presc   <= 0;
            m_idx     <= 0;
            m_idx_out <= 0;
        end else begin
            m_idx_out <= m_idx;
            if (m_presc == DIV - 1) begin
                m_presc <= 0;
                m_idx   <= (m_idx == DIGITS - 1) ? 0 : m_idx + 1;
            end else begin
                m_presc <= m_presc + 1;
            end
        end
    end

    int n_checks = 0;
    int n_errors = 0;

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    logic [31:0] rd_q[$];

    task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
        @(negedge clock);
        bus.cs = 1'b1; bus.wen = 1'b1; bus.addr = a; bus.wdata = d;
        @(negedge clock);
        bus.cs = 1'b0; bus.wen = 1'b0;
    endtask

    task automatic bus_read(input logic [1:0] a, input logic [31:0] exp, input string name);
        @(negedge clock);
        bus.cs = 1'b1; bus.ren = 1'b1; bus.addr = a;
        rd_q.push_back(exp);
        @(negedge clock);
        bus.cs = 1'b0; bus.ren = 1'b0;
        check32(name, bus.rdata, rd_q.pop_front());
    endtask

    task automatic measure_busy(input string name, input int exp);
        int n = 0;
        while (bus.busy === 1'b1 && n < 200) begin
            n++;
            @(negedge clock);
        end
        check32(name, n, exp);
    endtask

    typedef struct {
        int          idx;
        logic [23:0] exp;
    } disp_t;
    disp_t disp_q[$];

    task automatic check_display(input string name, input logic [31:0] d, input logic [7:0] lit);
        repeat (3) @(negedge clock);
        for (int k = 0; k < DIGITS; k++) begin
            disp_t      r;
            logic [7:0] pat;
            pat   = {1'b0, tb_glyph[d[4*k +: 4]]};
            r.idx = k;
            r.exp = {lit[k] ? 8'(1 << k) : 8'h00,
                     (lit[k] && k < 4)  ? pat : 8'h00,
                     (lit[k] && k >= 4) ? pat : 8'h00};
            disp_q.push_back(r);
        end
        while (disp_q.size() > 0) begin
            disp_t r = disp_q.pop_front();
            int    w = 0;
            @(negedge clock);
            while (m_idx_out != r.idx && w < 20 * DIV) begin
                w++;
                @(negedge clock);
            end
            if (w >= 20 * DIV) begin
                n_checks++;
                n_errors++;
                $display("FAIL %s timeout waiting for digit %0d", name, r.idx);
            end
            check32($sformatf("%s d%0d", name, r.idx), {8'h00, an, seg_lo, seg_hi}, {8'h00, r.exp});
        end
    endtask

    task automatic wait_mid();
        @(negedge clock);
        while (m_presc != DIV / 2) @(negedge clock);
    endtask

    typedef struct {
        logic [2:0]  mode;
        logic [7:0]  mask;
        logic [31:0] value;
        logic [31:0] exp_d;
        logic [7:0]  exp_lit;
    } vec_t;
    vec_t vecs[10];

    initial begin
        vecs[0] = '{3'd0, 8'hFF, 32'h12AB34CD,    32'h12AB34CD, 8'hFF};
        vecs[1] = '{3'd1, 8'hFF, 32'd12345678,    32'h12345678, 8'hFF};
        vecs[2] = '{3'd1, 8'hFF, 32'd4294967295,  32'h94967295, 8'hFF};
        vecs[3] = '{3'd3, 8'hFF, 32'd42,          32'h00000042, 8'h03};
        vecs[4] = '{3'd3, 8'hFE, 32'd42,          32'h00000042, 8'h02};
        vecs[5] = '{3'd2, 8'hFF, 32'h00000000,    32'h00000000, 8'h01};
        vecs[6] = '{3'd2, 8'hFF, 32'h00F00000,    32'h00F00000, 8'h3F};
        vecs[7] = '{3'd0, 8'h5A, 32'hFEDCBA98,    32'hFEDCBA98, 8'h5A};
        vecs[8] = '{3'd3, 8'hFF, 32'd100000000,   32'h00000000, 8'h01};
        vecs[9] = '{3'd1, 8'hFF, 32'd9,           32'h00000009, 8'hFF};

        bus.cs = 1'b0; bus.wen = 1'b0; bus.ren = 1'b0; bus.addr = 2'd0; bus.wdata = '0;
        rst = 1'b1;
        repeat (2) @(negedge clock);
        check32("reset an", {24'd0, an}, 32'h0);
        check32("reset seg_lo", {24'd0, seg_lo}, 32'h0);
        check32("reset seg_hi", {24'd0, seg_hi}, 32'h0);
        check32("reset busy", {31'd0, bus.busy}, 32'h0);
        check32("reset rdata", bus.rdata, 32'h0);
        rst = 1'b0;

        bus_read(2'd2, 32'h000000FF, "reset mask");
        bus_read(2'd0, 32'h0, "reset value");
        bus_read(2'd1, 32'h0, "reset mode");
        @(negedge clock);
        check32("rdata hold", bus.rdata, 32'h0);

        for (int v = 0; v < 10; v++) begin
            bus_write(2'd2, {24'd0, vecs[v].mask});
            bus_write(2'd1, {29'd0, vecs[v].mode});
            bus_write(2'd0, vecs[v].value);
            if (vecs[v].mode[0]) measure_busy($sformatf("busy v%0d", v), 33);
            bus_read(2'd3, 32'h0, $sformatf("status v%0d", v));
            bus_read(2'd0, vecs[v].value, $sformatf("rd value v%0d", v));
            bus_read(2'd1, {29'd0, vecs[v].mode}, $sformatf("rd mode v%0d", v));
            bus_read(2'd2, {24'd0, vecs[v].mask}, $sformatf("rd mask v%0d", v));
            check_display($sformatf("disp v%0d", v), vecs[v].exp_d, vecs[v].exp_lit);
        end

        // Restart in the middle of a conversion.
        bus_write(2'd1, 32'd1);
        measure_busy("busy mode write", 33);
        bus_write(2'd0, 32'd12345678);
        repeat (9) @(negedge clock);
        bus_write(2'd0, 32'd99);
        measure_busy("busy restart", 33);
        check_display("disp restart", 32'h00000099, 8'hFF);

        // STATUS during/after conversion; STATUS writes ignored.
        bus_write(2'd0, 32'd7);
        bus_read(2'd3, 32'h1, "status busy");
        measure_busy("busy remainder", 31);
        bus_read(2'd3, 32'h0, "status done");
        bus_write(2'd3, 32'hFFFFFFFF);
        measure_busy("status write no start", 0);
        bus_read(2'd0, 32'd7, "value after status write");
        bus_read(2'd1, 32'd1, "mode after status write");
        check_display("disp seven", 32'h00000007, 8'hFF);
        bus_write(2'd1, 32'hFFFFFFF8);
        bus_read(2'd1, 32'h0, "mode unused bits");

        // Blink: wait for the first dark tick, then check the 2-dark/2-lit rhythm.
        bus_write(2'd0, 32'h12345678);
        bus_write(2'd1, 32'd4);
        begin
            int w = 0;
            wait_mid();
            while (an != 8'h00 && w < 12) begin
                w++;
                wait_mid();
            end
            if (w >= 12) begin
                n_checks++;
                n_errors++;
                $display("FAIL blink never dark");
            end
        end
        for (int s = 0; s < 4; s++) begin
            logic [3:0] lit_seq;
            lit_seq = 4'b0110;
            wait_mid();
            check32($sformatf("blink s%0d", s), {24'd0, an},
                    lit_seq[s] ? 32'(1 << m_idx_out) : 32'h0);
        end
        bus_write(2'd1, 32'd0);
        wait_mid();
        check32("blink cleared", {24'd0, an}, 32'(1 << m_idx_out));

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

endmodule
